// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU operator sequencer.
// The state encodings double as the LED phase codes shown to the operator.
package alu_seq_pkg;

    localparam int unsigned WIDTH_DEF   = 6;
    localparam int unsigned OP_W_DEF    = 3;
    localparam int unsigned TIMEOUT_DEF = 16;

    // Encodings are the phase codes driven to the LEDs.
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_RUN  = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    // Opcodes understood by the ALU; the sequencer passes them through untouched.
    localparam logic [OP_W_DEF-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W_DEF-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W_DEF-1:0] OP_AND = 3'd2;
    localparam logic [OP_W_DEF-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W_DEF-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W_DEF-1:0] OP_NOT = 3'd5;
    localparam logic [OP_W_DEF-1:0] OP_SHL = 3'd6;
    localparam logic [OP_W_DEF-1:0] OP_SHR = 3'd7;

endpackage

// File: rtl/seq_timeout_ctr.sv
// seq_timeout_ctr: clearable up-counter for the RUN wait, with a terminal
// flag raised while the count equals TIMEOUT-1 (TIMEOUT legal range 2..255).
module seq_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic iclk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam logic [7:0] TERM_VAL = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    // Clear has priority; otherwise count once per enabled cycle.
    always_ff @(posedge iclk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign term = (cnt == TERM_VAL);

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: walks the operator through A, B and opcode entry from the
// switch bank (one step press each), launches the ALU, captures its result or
// a timeout, and strobes the display stage.
// Optional feature macro: ACCUM_EN -- when defined, a step in SHOW after a
// successful operation loads the result into A and goes straight to B entry.
//
// ALU handshake: alu_start is a single-cycle launch pulse on the first RUN
// cycle; alu_done qualifies alu_z/alu_of and is honoured only in RUN, possibly
// in the same cycle as alu_start. If done never comes within TIMEOUT RUN
// cycles, the result is zeroed and err is raised. Done beats timeout.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned OP_W    = OP_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             iclk,
    input  logic             rst,
    input  logic             step,
    input  logic [WIDTH-1:0] sw,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_z,
    input  logic             alu_of,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    output logic             alu_start,
    output logic [WIDTH-1:0] z_out,
    output logic             of_out,
    output logic             err,
    output logic             disp_load,
    output logic [2:0]       phase
);

    state_t state;
    logic   tmr_clr;
    logic   tmr_en;
    logic   tmr_term;

    // Timer restarts on the launching step and runs through every RUN cycle.
    assign tmr_clr = (state == S_OP) && step;
    assign tmr_en  = (state == S_RUN);

    seq_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .iclk (iclk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .term (tmr_term)
    );

    // Sequencer FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge iclk or negedge rst) begin
        if (!rst) begin
            state     <= S_A;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            alu_start <= 1'b0;
            z_out     <= '0;
            of_out    <= 1'b0;
            err       <= 1'b0;
            disp_load <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            disp_load <= 1'b0;
            case (state)
                S_A: begin
                    if (step) begin
                        alu_a <= sw;
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (step) begin
                        alu_b <= sw;
                        state <= S_OP;
                    end
                end
                S_OP: begin
                    if (step) begin
                        alu_op    <= sw[OP_W-1:0];
                        alu_start <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (alu_done) begin
                        z_out     <= alu_z;
                        of_out    <= alu_of;
                        err       <= 1'b0;
                        disp_load <= 1'b1;
                        state     <= S_SHOW;
                    end else if (tmr_term) begin
                        z_out     <= '0;
                        of_out    <= 1'b0;
                        err       <= 1'b1;
                        disp_load <= 1'b1;
                        state     <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (step) begin
`ifdef ACCUM_EN
                        if (!err) begin
                            alu_a <= z_out;
                            state <= S_B;
                        end else begin
                            state <= S_A;
                        end
`else
                        state <= S_A;
`endif
                    end
                end
                default: state <= S_A;
            endcase
        end
    end

    assign phase = state;

endmodule
